// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported, word-addressed data memory between the
//    MEM stage (port 0) and the debug/program loader (port 1); ties go round-robin.
// Latency (req sampled in IDLE -> gnt): write 2, read READ_LAT+2, out-of-range 1 cycle.
// Backpressure: one access in flight; requesters hold req until gnt, port 0 sees stall.
//
// Ports:
//    clock, reset_n            clock, asynchronous active-low reset
//    reqN, weN, addrN, wdataN  port N request; fields held stable until gntN
//    gntN, rdataN, errN        completion pulse, read data, out-of-range flag
//    stall                     req0 & ~gnt0, freezes the pipeline
//    mem_*                     data memory interface (writes on posedge with mem_write=1)
module dmem_arbiter #(
   parameter int DEPTH    = 8192,
   parameter int READ_LAT = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        gnt0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic        stall,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(READ_LAT);

   state_t      state;
   logic        last_grant;
   logic        sel;
   logic [3:0]  cnt;

   logic        pick;
   logic        pick_we;
   logic [31:0] pick_addr;
   logic [31:0] pick_wdata;
   logic        pick_oor;

   // With both ports requesting, the one not served last wins.
   assign pick       = (req0 && req1) ? ~last_grant : req1;
   assign pick_we    = pick ? we1    : we0;
   assign pick_addr  = pick ? addr1  : addr0;
   assign pick_wdata = pick ? wdata1 : wdata0;
   assign pick_oor   = (pick_addr >= DEPTH_W);

   assign stall = req0 & ~gnt0;

   // mem_address / mem_write_data double as the latched request address and data:
   // they are loaded on the selecting edge and held until the access leaves RESP.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         sel            <= 1'b0;
         cnt            <= 4'd0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_write      <= 1'b0;
         mem_read       <= 1'b0;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         err0           <= 1'b0;
         err1           <= 1'b0;
         rdata0         <= '0;
         rdata1         <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  sel            <= pick;
                  last_grant     <= pick;
                  mem_address    <= pick_addr;
                  mem_write_data <= pick_wdata;
                  if (pick_oor) begin
                     // Out-of-range: memory is never touched, complete with err.
                     state <= RESP;
                     if (pick) begin
                        gnt1 <= 1'b1;
                        err1 <= 1'b1;
                        if (!pick_we) rdata1 <= '0;
                     end else begin
                        gnt0 <= 1'b1;
                        err0 <= 1'b1;
                        if (!pick_we) rdata0 <= '0;
                     end
                  end else if (pick_we) begin
                     state     <= WRITE;
                     mem_write <= 1'b1;
                  end else begin
                     state    <= READ;
                     mem_read <= 1'b1;
                     cnt      <= CNT_INIT;
                  end
               end
            end
            WRITE: begin
               mem_write <= 1'b0;
               state     <= RESP;
               if (sel) gnt1 <= 1'b1;
               else     gnt0 <= 1'b1;
            end
            READ: begin
               // mem_read is held for READ_LAT cycles; the following cycle (cnt==0)
               // samples the memory's registered output and completes the access.
               if (cnt == 4'd0) begin
                  state <= RESP;
                  if (sel) begin
                     gnt1   <= 1'b1;
                     rdata1 <= mem_read_data;
                  end else begin
                     gnt0   <= 1'b1;
                     rdata0 <= mem_read_data;
                  end
               end else begin
                  cnt      <= cnt - 4'd1;
                  mem_read <= (cnt != 4'd1);
               end
            end
            RESP: begin
               state          <= IDLE;
               mem_address    <= '0;
               mem_write_data <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three dmem_arbiter instances (READ_LAT 2, 1, 4), each with a
//    registered-read memory model; directed accesses push expected grants into a
//    queue that a negedge monitor pops and compares.
module tb_dmem_arbiter;

   localparam int DEPTH = 8192;

   typedef struct {
      int          inst;
      int          port;
      int          cyc;
      logic        err;
      logic        chk;
      logic [31:0] rdata;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   int          cyc = 0;

   logic        req0 [3];
   logic        we0  [3];
   logic [31:0] addr0 [3];
   logic [31:0] wdata0 [3];
   logic        req1 [3];
   logic        we1  [3];
   logic [31:0] addr1 [3];
   logic [31:0] wdata1 [3];
   logic        gnt0 [3];
   logic        gnt1 [3];
   logic        err0 [3];
   logic        err1 [3];
   logic [31:0] rdata0 [3];
   logic [31:0] rdata1 [3];
   logic        stall [3];
   logic [31:0] mem_address [3];
   logic [31:0] mem_write_data [3];
   logic        mem_write [3];
   logic        mem_read [3];

   exp_t        exp_q [$];
   int          sw_from [$];
   int          sw_to [$];
   int          wr_hi [3];
   int          rd_hi [3];
   int          n_cmp;
   int          n_bad;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int RL = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [31:0] mem [DEPTH];
      logic [31:0] rd_q;

      dmem_arbiter #(.DEPTH(DEPTH), .READ_LAT(RL)) u_dut (
         .clock         (clock),
         .reset_n       (reset_n),
         .req0          (req0[g]),
         .we0           (we0[g]),
         .addr0         (addr0[g]),
         .wdata0        (wdata0[g]),
         .gnt0          (gnt0[g]),
         .rdata0        (rdata0[g]),
         .err0          (err0[g]),
         .req1          (req1[g]),
         .we1           (we1[g]),
         .addr1         (addr1[g]),
         .wdata1        (wdata1[g]),
         .gnt1          (gnt1[g]),
         .rdata1        (rdata1[g]),
         .err1          (err1[g]),
         .stall         (stall[g]),
         .mem_address   (mem_address[g]),
         .mem_write_data(mem_write_data[g]),
         .mem_write     (mem_write[g]),
         .mem_read      (mem_read[g]),
         .mem_read_data (rd_q)
      );

      always @(posedge clock) begin
         if (mem_write[g]) mem[mem_address[g][12:0]] <= mem_write_data[g];
         if (mem_read[g])  rd_q <= mem[mem_address[g][12:0]];
      end
   end

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void expect_gnt(input int g, input int port, input int at, input logic err,
                                      input logic chk, input logic [31:0] rd);
      exp_t e;
      e.inst = g; e.port = port; e.cyc = at; e.err = err; e.chk = chk; e.rdata = rd;
      exp_q.push_back(e);
   endfunction

   function automatic void stall_win(input int from, input int to);
      sw_from.push_back(from);
      sw_to.push_back(to);
   endfunction

   function automatic void mon_step();
      exp_t e;
      logic s_exp;
      for (int g = 0; g < 3; g++) begin
         if (mem_write[g]) wr_hi[g]++;
         if (mem_read[g])  rd_hi[g]++;
         check("rw_exclusive", 32'(mem_write[g] & mem_read[g]), 32'd0);
         if (mem_write[g] || mem_read[g])
            check("mem_in_range", 32'(mem_address[g] < 32'(DEPTH)), 32'd1);
         if (gnt0[g] || gnt1[g]) begin
            check("gnt_onehot", 32'(gnt0[g] & gnt1[g]), 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_gnt: inst %0d gnt0=%b gnt1=%b, required no grant (cycle %0d)",
                        g, gnt0[g], gnt1[g], cyc);
            end else begin
               e = exp_q.pop_front();
               check("gnt_who", 32'(g * 2 + (gnt1[g] ? 1 : 0)), 32'(e.inst * 2 + e.port));
               check("gnt_cycle", 32'(cyc), 32'(e.cyc));
               check("err", 32'(e.port != 0 ? err1[g] : err0[g]), 32'(e.err));
               if (e.chk) check("rdata", (e.port != 0) ? rdata1[g] : rdata0[g], e.rdata);
            end
         end
      end
      s_exp = 1'b0;
      foreach (sw_from[i]) if (cyc >= sw_from[i] && cyc < sw_to[i]) s_exp = 1'b1;
      check("stall", 32'(stall[0]), 32'(s_exp));
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one access at the current cycle; drops req in the IDLE cycle after gnt.
   task automatic access(input int g, input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input logic err, input logic [31:0] rd);
      if (port == 0) begin
         req0[g] = 1'b1; we0[g] = we; addr0[g] = addr; wdata0[g] = wd;
      end else begin
         req1[g] = 1'b1; we1[g] = we; addr1[g] = addr; wdata1[g] = wd;
      end
      expect_gnt(g, port, cyc + lat, err, ~we, rd);
      if (g == 0 && port == 0) stall_win(cyc, cyc + lat);
      repeat (lat + 1) tick();
      if (port == 0) req0[g] = 1'b0;
      else           req1[g] = 1'b0;
   endtask

   initial begin
      int b;
      int snap;
      n_cmp = 0;
      n_bad = 0;
      reset_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         wr_hi[g] = 0; rd_hi[g] = 0;
         req0[g] = 1'b0; we0[g] = 1'b0; addr0[g] = '0; wdata0[g] = '0;
         req1[g] = 1'b0; we1[g] = 1'b0; addr1[g] = '0; wdata1[g] = '0;
      end
      fork
         forever begin
            @(negedge clock);
            mon_step();
         end
      join_none

      // Reset state
      tick();
      tick();
      check("rst_gnt0", 32'(gnt0[0]), 32'd0);
      check("rst_gnt1", 32'(gnt1[0]), 32'd0);
      check("rst_err0", 32'(err0[0]), 32'd0);
      check("rst_err1", 32'(err1[0]), 32'd0);
      check("rst_rdata0", rdata0[0], 32'd0);
      check("rst_rdata1", rdata1[0], 32'd0);
      check("rst_mem_address", mem_address[0], 32'd0);
      check("rst_mem_wdata", mem_write_data[0], 32'd0);
      check("rst_mem_write", 32'(mem_write[0]), 32'd0);
      check("rst_mem_read", 32'(mem_read[0]), 32'd0);
      reset_n = 1'b1;

      // Reset in the middle of a read, then re-read the same word
      access(0, 0, 1'b1, 32'd5, 32'hA5A5_0005, 2, 1'b0, 32'd0);
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'd5;
      b = cyc;
      stall_win(b, b + 2);
      tick();
      tick();
      check("midread_mem_read", 32'(mem_read[0]), 32'd1);
      #2;
      reset_n = 1'b0;
      req0[0] = 1'b0;
      #1;
      check("abort_gnt0", 32'(gnt0[0]), 32'd0);
      check("abort_gnt1", 32'(gnt1[0]), 32'd0);
      check("abort_mem_read", 32'(mem_read[0]), 32'd0);
      check("abort_mem_address", mem_address[0], 32'd0);
      tick();
      reset_n = 1'b1;
      access(0, 0, 1'b0, 32'd5, 32'd0, 4, 1'b0, 32'hA5A5_0005);

      // Port 0 write then read
      access(0, 0, 1'b1, 32'd100, 32'hDEAD_BEEF, 2, 1'b0, 32'd0);
      access(0, 0, 1'b0, 32'd100, 32'd0, 4, 1'b0, 32'hDEAD_BEEF);

      // Simultaneous requests straight out of reset, held for four writes
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 32'd200; wdata0[0] = 32'h0000_C200;
      req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 32'd300; wdata1[0] = 32'h0000_C300;
      b = cyc;
      expect_gnt(0, 0, b + 2, 1'b0, 1'b0, 32'd0);
      expect_gnt(0, 1, b + 5, 1'b0, 1'b0, 32'd0);
      expect_gnt(0, 0, b + 8, 1'b0, 1'b0, 32'd0);
      expect_gnt(0, 1, b + 11, 1'b0, 1'b0, 32'd0);
      stall_win(b, b + 2);
      stall_win(b + 3, b + 8);
      repeat (3) tick();
      addr0[0] = 32'd201; wdata0[0] = 32'h0000_C201;
      repeat (3) tick();
      addr1[0] = 32'd301; wdata1[0] = 32'h0000_C301;
      repeat (3) tick();
      req0[0] = 1'b0;
      repeat (3) tick();
      req1[0] = 1'b0;
      access(0, 0, 1'b0, 32'd201, 32'd0, 4, 1'b0, 32'h0000_C201);
      access(0, 1, 1'b0, 32'd300, 32'd0, 4, 1'b0, 32'h0000_C300);
      access(0, 1, 1'b0, 32'd301, 32'd0, 4, 1'b0, 32'h0000_C301);
      check("rdata0_hold", rdata0[0], 32'h0000_C201);

      // Boundary addresses on port 1
      access(0, 1, 1'b1, 32'd8191, 32'h1234_5678, 2, 1'b0, 32'd0);
      access(0, 1, 1'b0, 32'd8191, 32'd0, 4, 1'b0, 32'h1234_5678);
      snap = wr_hi[0];
      access(0, 1, 1'b1, 32'd8192, 32'hBAD0_BAD0, 1, 1'b1, 32'd0);
      check("oor_write_cycles", 32'(wr_hi[0] - snap), 32'd0);
      snap = rd_hi[0];
      access(0, 1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1, 1'b1, 32'd0);
      check("oor_read_cycles", 32'(rd_hi[0] - snap), 32'd0);

      // READ_LAT=1 and READ_LAT=4 instances
      access(1, 0, 1'b1, 32'd7, 32'd7, 2, 1'b0, 32'd0);
      snap = rd_hi[1];
      access(1, 0, 1'b0, 32'd7, 32'd0, 3, 1'b0, 32'd7);
      check("rl1_mem_read_cycles", 32'(rd_hi[1] - snap), 32'd1);
      access(2, 0, 1'b1, 32'd7, 32'd7, 2, 1'b0, 32'd0);
      snap = rd_hi[2];
      access(2, 0, 1'b0, 32'd7, 32'd0, 6, 1'b0, 32'd7);
      check("rl4_mem_read_cycles", 32'(rd_hi[2] - snap), 32'd4);

      // Port 1 streaming writes, port 0 read arriving mid-access
      req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 32'd400; wdata1[0] = 32'h0000_0400;
      b = cyc;
      expect_gnt(0, 1, b + 2, 1'b0, 1'b0, 32'd0);
      tick();
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'd100;
      expect_gnt(0, 0, b + 7, 1'b0, 1'b1, 32'hDEAD_BEEF);
      stall_win(b + 1, b + 7);
      repeat (2) tick();
      addr1[0] = 32'd401; wdata1[0] = 32'h0000_0401;
      expect_gnt(0, 1, b + 10, 1'b0, 1'b0, 32'd0);
      repeat (5) tick();
      req0[0] = 1'b0;
      repeat (3) tick();
      addr1[0] = 32'd402; wdata1[0] = 32'h0000_0402;
      expect_gnt(0, 1, b + 13, 1'b0, 1'b0, 32'd0);
      repeat (3) tick();
      req1[0] = 1'b0;
      access(0, 0, 1'b0, 32'd401, 32'd0, 4, 1'b0, 32'h0000_0401);

      repeat (5) tick();
      check("gnt_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
